// File: rtl/pixel_out_packer.sv
// Packs byte stores aimed at a memory-mapped pixel port into 32-bit words and streams them out of a word FIFO.
// Optional feature: define PIXEL_OUT_FLUSH_EN so that a store to OUT_BASE_ADDR+4 emits the partial word.
module pixel_out_packer #(
    parameter logic [31:0] OUT_BASE_ADDR = 32'h0000_F000,
    parameter int unsigned FIFO_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_mem,
    input  logic [31:0] addr,
    input  logic [7:0]  dob_byte,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        fifo_full,
    output logic        overflow,
    output logic [15:0] pixel_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [1:0]    lane_idx_r;
    logic [31:0]   partial_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [31:0]   mem_r [FIFO_DEPTH];
    logic [31:0]   out_data_r;
    logic          out_valid_r;
    logic          fifo_full_r;
    logic          overflow_r;
    logic [15:0]   pixel_count_r;

    logic          accept_s;
    logic          flush_s;
    logic          complete_s;
    logic [31:0]   word_s;
    logic [1:0]    lane_nxt_s;
    logic [31:0]   partial_nxt_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic          empty_nxt_s;
    logic          full_nxt_s;
    logic [31:0]   head_nxt_s;

    // Port decode and lane packing; a completed word is taken from the partial register plus the current byte.
    always_comb begin
        accept_s      = we_mem && (addr == OUT_BASE_ADDR);
        flush_s       = 1'b0;
`ifdef PIXEL_OUT_FLUSH_EN
        flush_s       = we_mem && (addr == (OUT_BASE_ADDR + 32'd4)) && (lane_idx_r != 2'd0);
`endif
        complete_s    = 1'b0;
        word_s        = partial_r;
        lane_nxt_s    = lane_idx_r;
        partial_nxt_s = partial_r;
        if (accept_s) begin
            lane_nxt_s = lane_idx_r + 2'd1;
            case (lane_idx_r)
                2'd0:    partial_nxt_s[7:0]   = dob_byte;
                2'd1:    partial_nxt_s[15:8]  = dob_byte;
                2'd2:    partial_nxt_s[23:16] = dob_byte;
                default: begin
                    complete_s    = 1'b1;
                    word_s        = {dob_byte, partial_r[23:0]};
                    lane_nxt_s    = 2'd0;
                    partial_nxt_s = 32'h0000_0000;
                end
            endcase
        end else if (flush_s) begin
            // Unwritten upper lanes are already zero because the partial register clears on every emission.
            complete_s    = 1'b1;
            word_s        = partial_r;
            lane_nxt_s    = 2'd0;
            partial_nxt_s = 32'h0000_0000;
        end else begin
            lane_nxt_s    = lane_idx_r;
            partial_nxt_s = partial_r;
        end
    end

    // FIFO control; next-cycle head/status are computed here so the outputs come straight from registers.
    always_comb begin
        pop_s        = out_valid_r && out_ready;
        push_s       = complete_s && (!fifo_full_r || pop_s);
        drop_s       = complete_s && fifo_full_r && !pop_s;
        rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
        wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, push_s};
        empty_nxt_s  = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        full_nxt_s   = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                       (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
        if (empty_nxt_s) begin
            head_nxt_s = 32'h0000_0000;
        end else if (push_s && (wr_ptr_r[AW-1:0] == rd_ptr_nxt_s[AW-1:0])) begin
            head_nxt_s = word_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
        end
    end

    // Word storage; contents need no reset since the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= word_s;
        end
    end

    // Packer, pointer and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_idx_r    <= 2'd0;
            partial_r     <= 32'h0000_0000;
            wr_ptr_r      <= {PW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            out_data_r    <= 32'h0000_0000;
            out_valid_r   <= 1'b0;
            fifo_full_r   <= 1'b0;
            overflow_r    <= 1'b0;
            pixel_count_r <= 16'h0000;
        end else begin
            lane_idx_r    <= lane_nxt_s;
            partial_r     <= partial_nxt_s;
            wr_ptr_r      <= wr_ptr_nxt_s;
            rd_ptr_r      <= rd_ptr_nxt_s;
            out_data_r    <= head_nxt_s;
            out_valid_r   <= !empty_nxt_s;
            fifo_full_r   <= full_nxt_s;
            overflow_r    <= overflow_r || drop_s;
            pixel_count_r <= pixel_count_r + {15'd0, accept_s};
        end
    end

    assign out_data    = out_data_r;
    assign out_valid   = out_valid_r;
    assign fifo_full   = fifo_full_r;
    assign overflow    = overflow_r;
    assign pixel_count = pixel_count_r;

endmodule
